// File: rtl/matrix_loader.sv
// Streams an X matrix then a Y vector from AXI-Stream into two write-only RAM ports and kicks the multiplier.
// Optional build macro LOADER_TLAST_CHECK_EN adds a sticky frame_error output driven by tlast framing.
module matrix_loader #(
    parameter int width        = 8,
    parameter int X_words      = 1,
    parameter int Y_words      = 1,
    parameter int X_depth_bits = 1,
    parameter int Y_depth_bits = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [width-1:0]        s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic                    X_write_en,
    output logic [X_depth_bits-1:0] X_write_address,
    output logic [width-1:0]        X_write_data,
    output logic                    Y_write_en,
    output logic [Y_depth_bits-1:0] Y_write_address,
    output logic [width-1:0]        Y_write_data,
    output logic                    mmult_start,
    input  logic                    mmult_all_datapoints_done,
    output logic                    loader_busy
`ifdef LOADER_TLAST_CHECK_EN
    ,
    output logic                    frame_error
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_Y,
        START,
        WAIT_DONE
    } state_t;

    localparam logic [X_depth_bits-1:0] X_LAST = X_depth_bits'(X_words - 1);
    localparam logic [Y_depth_bits-1:0] Y_LAST = Y_depth_bits'(Y_words - 1);

    state_t                  state_q, state_d;
    logic [X_depth_bits-1:0] x_cnt_q, x_cnt_d;
    logic [Y_depth_bits-1:0] y_cnt_q, y_cnt_d;
    logic                    tready_q, tready_d;
    logic                    xwe_q, xwe_d;
    logic [X_depth_bits-1:0] xaddr_q, xaddr_d;
    logic [width-1:0]        xdata_q, xdata_d;
    logic                    ywe_q, ywe_d;
    logic [Y_depth_bits-1:0] yaddr_q, yaddr_d;
    logic [width-1:0]        ydata_q, ydata_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    done_prev_q;
    logic                    accept;
`ifdef LOADER_TLAST_CHECK_EN
    logic                    err_q, err_d;
`else
    logic                    unused_tlast;
    assign unused_tlast = s_axis_tlast;
`endif

    // tready_q is high exactly while in LOAD_X/LOAD_Y, so it doubles as the load-state qualifier
    assign accept = s_axis_tvalid & tready_q;

    always_comb begin
        state_d = state_q;
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        xwe_d   = 1'b0;
        xaddr_d = xaddr_q;
        xdata_d = xdata_q;
        ywe_d   = 1'b0;
        yaddr_d = yaddr_q;
        ydata_d = ydata_q;
        start_d = 1'b0;
`ifdef LOADER_TLAST_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                x_cnt_d = '0;
                y_cnt_d = '0;
                if (s_axis_tvalid) state_d = LOAD_X;
            end
            LOAD_X: begin
                if (accept) begin
                    xwe_d   = 1'b1;
                    xaddr_d = x_cnt_q;
                    xdata_d = s_axis_tdata;
                    if (x_cnt_q == X_LAST) begin
                        x_cnt_d = '0;
                        y_cnt_d = '0;
                        state_d = LOAD_Y;
                    end else begin
                        x_cnt_d = x_cnt_q + X_depth_bits'(1);
                    end
`ifdef LOADER_TLAST_CHECK_EN
                    if (s_axis_tlast) begin
                        err_d   = 1'b1;
                        x_cnt_d = '0;
                        y_cnt_d = '0;
                        state_d = IDLE;
                    end
`endif
                end
            end
            LOAD_Y: begin
                if (accept) begin
                    ywe_d   = 1'b1;
                    yaddr_d = y_cnt_q;
                    ydata_d = s_axis_tdata;
                    if (y_cnt_q == Y_LAST) begin
                        y_cnt_d = '0;
                        state_d = START;
`ifdef LOADER_TLAST_CHECK_EN
                        if (!s_axis_tlast) err_d = 1'b1;
`endif
                    end else begin
                        y_cnt_d = y_cnt_q + Y_depth_bits'(1);
`ifdef LOADER_TLAST_CHECK_EN
                        if (s_axis_tlast) begin
                            err_d   = 1'b1;
                            x_cnt_d = '0;
                            y_cnt_d = '0;
                            state_d = IDLE;
                        end
`endif
                    end
                end
            end
            START: begin
                start_d = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Only a fresh rising edge releases; a level left high from the previous job is ignored
                if (mmult_all_datapoints_done && !done_prev_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        tready_d = (state_d == LOAD_X) || (state_d == LOAD_Y);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            tready_q    <= 1'b0;
            xwe_q       <= 1'b0;
            xaddr_q     <= '0;
            xdata_q     <= '0;
            ywe_q       <= 1'b0;
            yaddr_q     <= '0;
            ydata_q     <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            tready_q    <= tready_d;
            xwe_q       <= xwe_d;
            xaddr_q     <= xaddr_d;
            xdata_q     <= xdata_d;
            ywe_q       <= ywe_d;
            yaddr_q     <= yaddr_d;
            ydata_q     <= ydata_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_prev_q <= mmult_all_datapoints_done;
        end
    end

`ifdef LOADER_TLAST_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign frame_error = err_q;
`endif

    assign s_axis_tready   = tready_q;
    assign X_write_en      = xwe_q;
    assign X_write_address = xaddr_q;
    assign X_write_data    = xdata_q;
    assign Y_write_en      = ywe_q;
    assign Y_write_address = yaddr_q;
    assign Y_write_data    = ydata_q;
    assign mmult_start     = start_q;
    assign loader_busy     = busy_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader with X_words=4, Y_words=2.
module tb_matrix_loader;
    localparam int W   = 8;
    localparam int XW  = 4;
    localparam int YW  = 2;
    localparam int XDB = 2;
    localparam int YDB = 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   tdata;
    logic           tvalid;
    logic           tready;
    logic           tlast;
    logic           xwe;
    logic [XDB-1:0] xaddr;
    logic [W-1:0]   xdata;
    logic           ywe;
    logic [YDB-1:0] yaddr;
    logic [W-1:0]   ydata;
    logic           start;
    logic           done;
    logic           busy;
`ifdef LOADER_TLAST_CHECK_EN
    logic           frame_error;
`endif

    matrix_loader #(
        .width(W), .X_words(XW), .Y_words(YW), .X_depth_bits(XDB), .Y_depth_bits(YDB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_axis_tdata(tdata),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .s_axis_tlast(tlast),
        .X_write_en(xwe),
        .X_write_address(xaddr),
        .X_write_data(xdata),
        .Y_write_en(ywe),
        .Y_write_address(yaddr),
        .Y_write_data(ydata),
        .mmult_start(start),
        .mmult_all_datapoints_done(done),
        .loader_busy(busy)
`ifdef LOADER_TLAST_CHECK_EN
        ,
        .frame_error(frame_error)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          starts_seen = 0;
    logic        prev_start = 1'b0;
    logic [15:0] xq[$];
    logic [15:0] yq[$];
    int          startq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got event with value %0h, expected no event", name, got);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a start pulse
    always @(negedge clk) begin
        logic [15:0] e;
        if (xwe) begin
            if (xq.size() == 0) unexpected("x_write_unexpected", {22'd0, xaddr, xdata});
            else begin
                e = xq.pop_front();
                check("x_addr", 32'(xaddr), {24'd0, e[15:8]});
                check("x_data", 32'(xdata), {24'd0, e[7:0]});
            end
        end
        if (ywe) begin
            if (yq.size() == 0) unexpected("y_write_unexpected", {23'd0, yaddr, ydata});
            else begin
                e = yq.pop_front();
                check("y_addr", 32'(yaddr), {24'd0, e[15:8]});
                check("y_data", 32'(ydata), {24'd0, e[7:0]});
            end
        end
        if (start) begin
            starts_seen++;
            check("start_width", 32'(prev_start), 32'd0);
            if (startq.size() == 0) unexpected("start_unexpected", 32'(starts_seen));
            else begin
                void'(startq.pop_front());
                check("start_before_x_done", xq.size(), 32'd0);
                check("start_before_y_done", yq.size(), 32'd0);
            end
        end
        prev_start = start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = 8'hEE;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        logic rdy;
        int   n;
        n      = 0;
        tdata  = d;
        tvalid = 1'b1;
        tlast  = last;
        forever begin
            rdy = tready;
            tick();
            if (rdy) break;
            n++;
            if (n > 50) begin
                check("beat_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] base, input int gap);
        for (int i = 0; i < XW; i++) xq.push_back({8'(i), 8'(base + 8'(i) + 8'd1)});
        for (int i = 0; i < YW; i++) yq.push_back({8'(i), 8'(base + 8'(i) + 8'd5)});
        startq.push_back(1);
        for (int i = 0; i < XW + YW; i++) begin
            send_beat(8'(base + 8'(i) + 8'd1), (i == XW + YW - 1));
            if (i == 1 && gap > 0) begin
                idle();
                repeat (gap) tick();
            end
        end
        idle();
    endtask

    task automatic wait_start(input int target);
        int n;
        n = 0;
        while (starts_seen < target && n < 100) begin
            tick();
            n++;
        end
        check("start_count", 32'(starts_seen), 32'(target));
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_tready", 32'(tready), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_xwe",    32'(xwe),    32'd0);
        check("rst_ywe",    32'(ywe),    32'd0);
        check("rst_start",  32'(start),  32'd0);
        check("rst_xaddr",  32'(xaddr),  32'd0);
        check("rst_xdata",  32'(xdata),  32'd0);
        check("rst_yaddr",  32'(yaddr),  32'd0);
        check("rst_ydata",  32'(ydata),  32'd0);
`ifdef LOADER_TLAST_CHECK_EN
        check("rst_frame_error", 32'(frame_error), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        tvalid = 1'b0;
        tdata  = '0;
        tlast  = 1'b0;
        done   = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        reset = 1'b0;
        tick();

        // Basic frame, tvalid held high
        send_frame(8'h00, 0);
        wait_start(1);
        tick();
        tick();
        check("busy_in_wait", 32'(busy), 32'd1);
        check("tready_in_wait", 32'(tready), 32'd0);
        pulse_done();

        // tvalid gap of 3 cycles after beat 2
        send_frame(8'h00, 3);
        wait_start(2);
        pulse_done();

        // done already high before START must not release WAIT_DONE
        done = 1'b1;
        tick();
        send_frame(8'h10, 0);
        wait_start(3);
        repeat (4) tick();
        check("busy_done_level_held", 32'(busy), 32'd1);
        done = 1'b0;
        tick();
        check("busy_done_low", 32'(busy), 32'd1);
        done = 1'b1;
        tick();
        tick();
        check("busy_after_done_edge", 32'(busy), 32'd0);
        done = 1'b0;
        tick();

        // Reset after beat 3 abandons the frame
        for (int i = 0; i < 3; i++) xq.push_back({8'(i), 8'(8'h21 + 8'(i))});
        send_beat(8'h21, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h23, 1'b0);
        idle();
        tick();
        reset = 1'b1;
        #2;
        check_reset_outputs();
        tick();
        reset = 1'b0;
        tick();
        send_frame(8'h30, 0);
        wait_start(4);
        pulse_done();

        // Back-to-back frames
        send_frame(8'h40, 0);
        wait_start(5);
        pulse_done();
        send_frame(8'h50, 0);
        wait_start(6);
        pulse_done();

`ifdef LOADER_TLAST_CHECK_EN
        check("frame_error_clean", 32'(frame_error), 32'd0);
        for (int i = 0; i < 3; i++) xq.push_back({8'(i), 8'(8'h61 + 8'(i))});
        send_beat(8'h61, 1'b0);
        send_beat(8'h62, 1'b0);
        send_beat(8'h63, 1'b1);
        idle();
        tick();
        check("frame_error_set", 32'(frame_error), 32'd1);
        check("busy_after_tlast_abort", 32'(busy), 32'd0);
        repeat (5) tick();
        check("frame_error_sticky", 32'(frame_error), 32'd1);
`endif

        repeat (5) tick();
        check("final_starts", 32'(starts_seen), 32'd6);
        check("xq_empty", xq.size(), 32'd0);
        check("yq_empty", yq.size(), 32'd0);
        check("startq_empty", startq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
